vram_cpu_write_buffer: RTL and testbench
========================================

// Module: vram_cpu_write_buffer
// PURPOSE
//  Upstream CPU-side front end for the video VRAM sequencer (all logic on pixClk).
//  - Synchronises 68030 bus strobes into pixClk.
//  - Posts CPU writes into a small FIFO and acks them at once; sequencer drains the FIFO.
//  - Serialises reads behind pending writes so read-after-write returns fresh data.
//  - Register address 0xFFFF is an ordinary entry here; the sequencer decodes it.
// PARAMETERS
//  DEPTH        4   FIFO entries; power of two, >=2
//  SYNC_STAGES  2   flops on nCpuCE/nCpuDS synchronisers, >=2
// PORTS
//  pixClk       in   1   sole clock, rising edge; 25.175MHz pixel clock
//  reset        in   1   async, active-high reset
//  nCpuCE       in   1   CPU chip enable, active low, async to pixClk
//  nCpuDS       in   1   CPU data strobe, active low, async to pixClk
//  cpuRnW       in   1   1=read 0=write; stable while DS low
//  cpuAddr      in   16  CPU byte address
//  cpuDataIn    in   8   CPU write data
//  cpuDataOut   out  8   read data to CPU bus
//  cpuDataOe    out  1   drive cpuDataOut onto CPU bus
//  nCpuDSACKOut out  1   0 = acknowledge (board drives open-drain/tri-state)
//  wrReq        out  1   FIFO head valid
//  wrAddr       out  16  FIFO head address
//  wrData       out  8   FIFO head data
//  wrGrant      in   1   1-cycle pulse: sequencer consumed head
//  rdReq        out  1   CPU read request to sequencer
//  rdAddr       out  16  read address (latched)
//  rdGrant      in   1   1-cycle pulse: rdData valid this cycle
//  rdData       in   8   VRAM/register read data
//  fifoCount    out  clog2(DEPTH)+1  occupied entries
// BEHAVIOUR
//  Reset
//  - All FIFO pointers and count cleared; state=IDLE.
//  - cpuDataOut=0, cpuDataOe=0, nCpuDSACKOut=1, wrReq=0, rdReq=0, rdAddr=0.
//  - Reset asserted mid-cycle aborts it: a granted entry is lost and DSACK is not issued.
//  Synchronisers and bus strobe
//  - ceS/dsS are nCpuCE/nCpuDS after SYNC_STAGES flops.
//  - A bus cycle is recognised when ceS=0 and dsS=0.
//  - cpuRnW, cpuAddr and cpuDataIn are sampled only in that cycle; no extra sync.
//  FIFO
//  - wrReq = (count != 0); wrAddr/wrData show the head combinationally.
//  - wrGrant pops the head; wrGrant while empty is ignored.
//  - Push and pop in the same cycle: count unchanged, both pointers advance.
//  - Pointers wrap modulo DEPTH. Count is never >DEPTH and never <0.
//  State machine (one transition per rising edge)
//  - IDLE: on strobe:
//    - write with count<DEPTH: push {cpuAddr,cpuDataIn} -> ACK.
//    - write with FIFO full -> FULL.
//    - read: latch rdAddr -> RDWAIT.
//  - FULL: push on the first edge with count<DEPTH (including the edge of a same-cycle pop) -> ACK.
//  - RDWAIT: when count==0 and no wrGrant this cycle -> RDREQ.
//  - RDREQ: rdReq=1; on rdGrant, cpuDataOut<=rdData -> ACK.
//  - ACK: wait while dsS=0; on dsS=1 -> IDLE, and cpuDataOut is kept.
//  - Any strobe loss before ACK (dsS=1 or ceS=1 in FULL/RDWAIT) -> IDLE; nothing is pushed.
//  - Exception: RDREQ holds until rdGrant, because the sequencer is committed.
//  Outputs
//  - nCpuDSACKOut = !(state==ACK && !nCpuCE && !nCpuDS).
//    Uses raw strobes, so release is combinational when the CPU negates.
//  - cpuDataOe = state==ACK && read-cycle && !nCpuCE && !nCpuDS.
//  Latency
//  - Posted write: strobe sync + 1 clk to ACK (~SYNC_STAGES+1 clk).
//  - Read: FIFO drain + grant wait + 1.
//  Ordering
//  - Writes reach the sequencer in CPU order.
//  - A read never issues while any earlier write is still queued.
// TESTING
//  1 Reset: assert reset mid-ACK -> DSACK=1, Oe=0, fifoCount=0, wrReq=0 in same cycle (async).
//  2 Write 0x1234<=0xA5 with wrGrant held low:
//    - DSACK low within SYNC_STAGES+1 clks.
//    - wrReq=1, wrAddr=0x1234, wrData=0xA5, fifoCount=1.
//  3 Five writes with wrGrant low (DEPTH=4):
//    - 5th cycle stalls in FULL with DSACK high.
//    - One wrGrant pulse -> 5th pushed, DSACK low, fifoCount=4.
//  4 Write 0x0010<=0x3C, then read 0x0010 with grants delayed 6 clks:
//    - rdReq stays 0 until fifoCount=0.
//    - rdGrant with rdData=0x3C -> cpuDataOut=0x3C, Oe=1, DSACK low.
//  5 Simultaneous push+pop at count=2 -> count stays 2; wrAddr advances to the next entry.
//    Pointer wrap after 9 pushes/pops matches the reference model.
//  6 Write to 0xFFFF data 0x0D -> queued as a normal entry (wrAddr=0xFFFF, wrData=0x0D).
//    Strobe negated during FULL -> IDLE, nothing pushed.

Source files
------------

// File: rtl/vram_cpu_write_buffer.sv
// CPU-side front end for the VRAM sequencer, entirely on pixClk.
// Synchronises 68030 strobes, posts writes through a FIFO and orders reads behind them.
module vram_cpu_write_buffer #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   pixClk,
    input  logic                   reset,
    input  logic                   nCpuCE,
    input  logic                   nCpuDS,
    input  logic                   cpuRnW,
    input  logic [15:0]            cpuAddr,
    input  logic [7:0]             cpuDataIn,
    output logic [7:0]             cpuDataOut,
    output logic                   cpuDataOe,
    output logic                   nCpuDSACKOut,
    output logic                   wrReq,
    output logic [15:0]            wrAddr,
    output logic [7:0]             wrData,
    input  logic                   wrGrant,
    output logic                   rdReq,
    output logic [15:0]            rdAddr,
    input  logic                   rdGrant,
    input  logic [7:0]             rdData,
    output logic [$clog2(DEPTH):0] fifoCount
);
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FULL   = 3'd1,
        RDWAIT = 3'd2,
        RDREQ  = 3'd3,
        ACK    = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    logic [SYNC_STAGES-1:0] ce_sync;
    logic [SYNC_STAGES-1:0] ds_sync;
    logic                   ce_s;
    logic                   ds_s;
    logic                   strobe;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              pop;

    logic              push;
    logic              push_from_hold;
    logic              latch_write;
    logic              latch_read;
    logic              load_rd_data;
    logic [ADDR_W-1:0] push_addr;
    logic [DATA_W-1:0] push_data;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_data;
    logic              is_read;

    // Strobe synchronisers; idle level is high so reset looks like a negated bus.
    always_ff @(posedge pixClk or posedge reset) begin
        if (reset) begin
            ce_sync <= '1;
            ds_sync <= '1;
        end else begin
            ce_sync <= {ce_sync[SYNC_STAGES-2:0], nCpuCE};
            ds_sync <= {ds_sync[SYNC_STAGES-2:0], nCpuDS};
        end
    end

    assign ce_s   = ce_sync[SYNC_STAGES-1];
    assign ds_s   = ds_sync[SYNC_STAGES-1];
    assign strobe = !ce_s && !ds_s;

    assign full  = (count == CNT_W'(DEPTH));
    assign pop   = wrGrant && (count != '0);
    assign wrReq = (count != '0);

    assign wrAddr    = addr_mem[rd_ptr];
    assign wrData    = data_mem[rd_ptr];
    assign fifoCount = count;

    assign push_addr = push_from_hold ? hold_addr : cpuAddr;
    assign push_data = push_from_hold ? hold_data : cpuDataIn;

    // State register.
    always_ff @(posedge pixClk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and FIFO/datapath strobes.
    always_comb begin
        state_next     = state;
        push           = 1'b0;
        push_from_hold = 1'b0;
        latch_write    = 1'b0;
        latch_read     = 1'b0;
        load_rd_data   = 1'b0;
        case (state)
            IDLE: begin
                if (strobe) begin
                    if (cpuRnW) begin
                        latch_read = 1'b1;
                        state_next = RDWAIT;
                    end else if (!full) begin
                        push       = 1'b1;
                        state_next = ACK;
                    end else begin
                        latch_write = 1'b1;
                        state_next  = FULL;
                    end
                end
            end
            FULL: begin
                if (!strobe) begin
                    state_next = IDLE;
                end else if (!full || pop) begin
                    push           = 1'b1;
                    push_from_hold = 1'b1;
                    state_next     = ACK;
                end
            end
            RDWAIT: begin
                if (!strobe) begin
                    state_next = IDLE;
                end else if ((count == '0) && !wrGrant) begin
                    state_next = RDREQ;
                end
            end
            RDREQ: begin
                // The sequencer is committed once asked, so strobe loss is ignored here.
                if (rdGrant) begin
                    load_rd_data = 1'b1;
                    state_next   = ACK;
                end
            end
            ACK: begin
                if (ds_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge pixClk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; a full push can only happen alongside a pop, so overwriting the head is safe.
    always_ff @(posedge pixClk) begin
        if (push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
    end

    // Cycle capture, read request and read data return.
    always_ff @(posedge pixClk or posedge reset) begin
        if (reset) begin
            is_read    <= 1'b0;
            hold_addr  <= '0;
            hold_data  <= '0;
            rdAddr     <= '0;
            rdReq      <= 1'b0;
            cpuDataOut <= '0;
        end else begin
            if (state == IDLE && strobe) begin
                is_read <= cpuRnW;
            end
            if (latch_write) begin
                hold_addr <= cpuAddr;
                hold_data <= cpuDataIn;
            end
            if (latch_read) begin
                rdAddr <= cpuAddr;
            end
            rdReq <= (state_next == RDREQ);
            if (load_rd_data) begin
                cpuDataOut <= rdData;
            end
        end
    end

    // Raw strobes let DSACK and the data driver drop the moment the CPU negates.
    assign nCpuDSACKOut = !(state == ACK && !nCpuCE && !nCpuDS);
    assign cpuDataOe    = (state == ACK) && is_read && !nCpuCE && !nCpuDS;

endmodule

// File: tb/tb_vram_cpu_write_buffer.sv
// Directed bench for vram_cpu_write_buffer: posted writes, stalls, read ordering, wrap and abort.
module tb_vram_cpu_write_buffer;
    logic        pixClk;
    logic        reset;
    logic        nCpuCE;
    logic        nCpuDS;
    logic        cpuRnW;
    logic [15:0] cpuAddr;
    logic [7:0]  cpuDataIn;
    logic [7:0]  cpuDataOut;
    logic        cpuDataOe;
    logic        nCpuDSACKOut;
    logic        wrReq;
    logic [15:0] wrAddr;
    logic [7:0]  wrData;
    logic        wrGrant;
    logic        rdReq;
    logic [15:0] rdAddr;
    logic        rdGrant;
    logic [7:0]  rdData;
    logic [2:0]  fifoCount;

    int errors = 0;
    int checks = 0;
    logic [23:0] model[$];

    vram_cpu_write_buffer #(.DEPTH(4), .SYNC_STAGES(2)) dut (
        .pixClk(pixClk), .reset(reset), .nCpuCE(nCpuCE), .nCpuDS(nCpuDS),
        .cpuRnW(cpuRnW), .cpuAddr(cpuAddr), .cpuDataIn(cpuDataIn),
        .cpuDataOut(cpuDataOut), .cpuDataOe(cpuDataOe), .nCpuDSACKOut(nCpuDSACKOut),
        .wrReq(wrReq), .wrAddr(wrAddr), .wrData(wrData), .wrGrant(wrGrant),
        .rdReq(rdReq), .rdAddr(rdAddr), .rdGrant(rdGrant), .rdData(rdData),
        .fifoCount(fifoCount)
    );

    initial pixClk = 1'b0;
    always #5 pixClk = ~pixClk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_strobe(input logic rnw, input logic [15:0] addr, input logic [7:0] data);
        @(negedge pixClk);
        cpuRnW = rnw; cpuAddr = addr; cpuDataIn = data;
        nCpuCE = 1'b0; nCpuDS = 1'b0;
    endtask

    task automatic release_strobe();
        @(negedge pixClk);
        nCpuCE = 1'b1; nCpuDS = 1'b1; wrGrant = 1'b0; rdGrant = 1'b0;
        repeat (4) @(posedge pixClk);
    endtask

    task automatic wait_ack(input int max_cycles, output int cycles);
        cycles = 0;
        for (int i = 1; i <= max_cycles; i++) begin
            @(posedge pixClk); #1;
            if (nCpuDSACKOut === 1'b0) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic grant_pulse();
        @(negedge pixClk); wrGrant = 1'b1;
        @(negedge pixClk); wrGrant = 1'b0;
    endtask

    task automatic posted_write(input logic [15:0] addr, input logic [7:0] data, output int cycles);
        drive_strobe(1'b0, addr, data);
        wait_ack(8, cycles);
        release_strobe();
    endtask

    // Write whose push edge coincides with a wrGrant pop; returns 1ns after that edge.
    task automatic write_with_pop(input logic [15:0] addr, input logic [7:0] data);
        drive_strobe(1'b0, addr, data);
        @(posedge pixClk); @(posedge pixClk);
        @(negedge pixClk); wrGrant = 1'b1;
        @(posedge pixClk); #1;
    endtask

    task automatic test_reset();
        int cyc;
        #1;
        checks++; if (nCpuDSACKOut !== 1'b1) begin errors++; $display("FAIL rst_dsack: got %b want 1", nCpuDSACKOut); end
        checks++; if (cpuDataOe !== 1'b0) begin errors++; $display("FAIL rst_oe: got %b want 0", cpuDataOe); end
        checks++; if (wrReq !== 1'b0 || rdReq !== 1'b0) begin errors++; $display("FAIL rst_req: got wr=%b rd=%b want 0 0", wrReq, rdReq); end
        checks++; if (rdAddr !== 16'h0000 || cpuDataOut !== 8'h00) begin errors++; $display("FAIL rst_regs: got rdAddr=%h out=%h want 0000 00", rdAddr, cpuDataOut); end
        checks++; if (fifoCount !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", fifoCount); end
        @(negedge pixClk); reset = 1'b0;
        drive_strobe(1'b0, 16'h5555, 8'h55);
        wait_ack(8, cyc);
        checks++; if (cyc == 0 || fifoCount !== 3'd1) begin errors++; $display("FAIL rst_pre_ack: got cycles=%0d count=%0d want ack count=1", cyc, fifoCount); end
        @(posedge pixClk); #3;
        reset = 1'b1; #1;
        checks++; if (nCpuDSACKOut !== 1'b1 || cpuDataOe !== 1'b0) begin errors++; $display("FAIL rst_mid_ack: got dsack=%b oe=%b want 1 0", nCpuDSACKOut, cpuDataOe); end
        checks++; if (fifoCount !== 3'd0 || wrReq !== 1'b0) begin errors++; $display("FAIL rst_mid_fifo: got count=%0d wrReq=%b want 0 0", fifoCount, wrReq); end
        nCpuCE = 1'b1; nCpuDS = 1'b1;
        repeat (2) @(negedge pixClk);
        reset = 1'b0;
        repeat (3) @(posedge pixClk);
    endtask

    task automatic test_single_write();
        int cyc;
        drive_strobe(1'b0, 16'h1234, 8'hA5);
        wait_ack(8, cyc);
        checks++; if (cyc == 0 || cyc > 3) begin errors++; $display("FAIL wr_latency: got %0d clks want 1..3", cyc); end
        checks++; if (wrReq !== 1'b1 || fifoCount !== 3'd1) begin errors++; $display("FAIL wr_req: got wrReq=%b count=%0d want 1 1", wrReq, fifoCount); end
        checks++; if (wrAddr !== 16'h1234 || wrData !== 8'hA5) begin errors++; $display("FAIL wr_head: got %h/%h want 1234/a5", wrAddr, wrData); end
        release_strobe();
        grant_pulse();
        checks++; if (fifoCount !== 3'd0 || wrReq !== 1'b0) begin errors++; $display("FAIL wr_drain: got count=%0d wrReq=%b want 0 0", fifoCount, wrReq); end
    endtask

    task automatic test_full_stall();
        int cyc;
        for (int i = 0; i < 4; i++) begin
            posted_write(16'h0100 + 16'(i), 8'h10 + 8'(i), cyc);
            checks++; if (cyc == 0) begin errors++; $display("FAIL full_fill_ack%0d: got no ack want ack", i); end
        end
        checks++; if (fifoCount !== 3'd4) begin errors++; $display("FAIL full_count: got %0d want 4", fifoCount); end
        drive_strobe(1'b0, 16'h0104, 8'h14);
        repeat (6) @(posedge pixClk);
        #1;
        checks++; if (nCpuDSACKOut !== 1'b1) begin errors++; $display("FAIL full_stall: got dsack=%b want 1", nCpuDSACKOut); end
        grant_pulse();
        checks++; if (nCpuDSACKOut !== 1'b0 || fifoCount !== 3'd4) begin errors++; $display("FAIL full_release: got dsack=%b count=%0d want 0 4", nCpuDSACKOut, fifoCount); end
        checks++; if (wrAddr !== 16'h0101) begin errors++; $display("FAIL full_head: got %h want 0101", wrAddr); end
        release_strobe();
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (wrAddr !== 16'h0100 + 16'(i) || wrData !== 8'h10 + 8'(i)) begin
                errors++; $display("FAIL full_order%0d: got %h/%h want %h/%h", i, wrAddr, wrData, 16'h0100 + 16'(i), 8'h10 + 8'(i));
            end
            grant_pulse();
        end
        checks++; if (fifoCount !== 3'd0) begin errors++; $display("FAIL full_empty: got %0d want 0", fifoCount); end
    endtask

    task automatic test_read_after_write();
        int cyc;
        posted_write(16'h0010, 8'h3C, cyc);
        checks++; if (cyc == 0 || fifoCount !== 3'd1) begin errors++; $display("FAIL raw_write: got cycles=%0d count=%0d want ack 1", cyc, fifoCount); end
        drive_strobe(1'b1, 16'h0010, 8'h00);
        for (int i = 0; i < 6; i++) begin
            @(posedge pixClk); #1;
            checks++; if (rdReq !== 1'b0) begin errors++; $display("FAIL raw_blocked%0d: got rdReq=%b want 0", i, rdReq); end
        end
        grant_pulse();
        checks++; if (fifoCount !== 3'd0) begin errors++; $display("FAIL raw_drained: got %0d want 0", fifoCount); end
        repeat (6) @(posedge pixClk);
        #1;
        checks++; if (rdReq !== 1'b1 || rdAddr !== 16'h0010) begin errors++; $display("FAIL raw_req: got rdReq=%b rdAddr=%h want 1 0010", rdReq, rdAddr); end
        checks++; if (nCpuDSACKOut !== 1'b1) begin errors++; $display("FAIL raw_noack: got %b want 1", nCpuDSACKOut); end
        @(negedge pixClk); rdGrant = 1'b1; rdData = 8'h3C;
        @(negedge pixClk); rdGrant = 1'b0; rdData = 8'h00;
        checks++; if (cpuDataOut !== 8'h3C || cpuDataOe !== 1'b1) begin errors++; $display("FAIL raw_data: got out=%h oe=%b want 3c 1", cpuDataOut, cpuDataOe); end
        checks++; if (nCpuDSACKOut !== 1'b0 || rdReq !== 1'b0) begin errors++; $display("FAIL raw_ack: got dsack=%b rdReq=%b want 0 0", nCpuDSACKOut, rdReq); end
        nCpuCE = 1'b1; nCpuDS = 1'b1; #1;
        checks++; if (nCpuDSACKOut !== 1'b1 || cpuDataOe !== 1'b0) begin errors++; $display("FAIL raw_negate: got dsack=%b oe=%b want 1 0", nCpuDSACKOut, cpuDataOe); end
        repeat (4) @(posedge pixClk);
        #1;
        checks++; if (cpuDataOut !== 8'h3C) begin errors++; $display("FAIL raw_keep: got %h want 3c", cpuDataOut); end
    endtask

    task automatic test_push_pop_wrap();
        int cyc;
        model.delete();
        posted_write(16'h0200, 8'h20, cyc); model.push_back({16'h0200, 8'h20});
        posted_write(16'h0201, 8'h21, cyc); model.push_back({16'h0201, 8'h21});
        checks++; if (fifoCount !== 3'd2 || wrAddr !== 16'h0200) begin errors++; $display("FAIL pp_setup: got count=%0d head=%h want 2 0200", fifoCount, wrAddr); end
        for (int k = 0; k < 10; k++) begin
            write_with_pop(16'h0300 + 16'(k), 8'h40 + 8'(k));
            void'(model.pop_front());
            model.push_back({16'h0300 + 16'(k), 8'h40 + 8'(k)});
            checks++; if (nCpuDSACKOut !== 1'b0 || fifoCount !== 3'(model.size())) begin errors++; $display("FAIL pp_count%0d: got dsack=%b count=%0d want 0 %0d", k, nCpuDSACKOut, fifoCount, model.size()); end
            checks++; if ({wrAddr, wrData} !== model[0]) begin errors++; $display("FAIL pp_head%0d: got %h%h want %h", k, wrAddr, wrData, model[0]); end
            release_strobe();
        end
        while (model.size() > 0) begin
            checks++; if ({wrAddr, wrData} !== model[0]) begin errors++; $display("FAIL pp_drain: got %h%h want %h", wrAddr, wrData, model[0]); end
            grant_pulse();
            void'(model.pop_front());
        end
        checks++; if (fifoCount !== 3'd0) begin errors++; $display("FAIL pp_empty: got %0d want 0", fifoCount); end
    endtask

    task automatic test_reg_addr_and_abort();
        int cyc;
        posted_write(16'hFFFF, 8'h0D, cyc);
        checks++; if (wrAddr !== 16'hFFFF || wrData !== 8'h0D || fifoCount !== 3'd1) begin errors++; $display("FAIL reg_entry: got %h/%h count=%0d want ffff/0d 1", wrAddr, wrData, fifoCount); end
        for (int i = 0; i < 3; i++) posted_write(16'h0400 + 16'(i), 8'h50 + 8'(i), cyc);
        checks++; if (fifoCount !== 3'd4) begin errors++; $display("FAIL abort_fill: got %0d want 4", fifoCount); end
        drive_strobe(1'b0, 16'h0500, 8'h77);
        repeat (5) @(posedge pixClk);
        #1;
        checks++; if (nCpuDSACKOut !== 1'b1) begin errors++; $display("FAIL abort_stall: got %b want 1", nCpuDSACKOut); end
        release_strobe();
        grant_pulse();
        repeat (2) @(posedge pixClk);
        #1;
        checks++; if (fifoCount !== 3'd3 || nCpuDSACKOut !== 1'b1) begin errors++; $display("FAIL abort_nopush: got count=%0d dsack=%b want 3 1", fifoCount, nCpuDSACKOut); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (wrAddr !== 16'h0400 + 16'(i)) begin errors++; $display("FAIL abort_order%0d: got %h want %h", i, wrAddr, 16'h0400 + 16'(i)); end
            grant_pulse();
        end
        checks++; if (fifoCount !== 3'd0 || wrReq !== 1'b0) begin errors++; $display("FAIL abort_empty: got count=%0d wrReq=%b want 0 0", fifoCount, wrReq); end
    endtask

    initial begin
        reset = 1'b1; nCpuCE = 1'b1; nCpuDS = 1'b1; cpuRnW = 1'b0;
        cpuAddr = 16'h0000; cpuDataIn = 8'h00;
        wrGrant = 1'b0; rdGrant = 1'b0; rdData = 8'h00;
        repeat (2) @(posedge pixClk);
        test_reset();
        test_single_write();
        test_full_stall();
        test_read_after_write();
        test_push_pop_wrap();
        test_reg_addr_and_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
